// File: rtl/decode_issue_stage.sv
// decode_issue_stage: decodes one instruction per cycle into a one-entry issue register, with a RAW/WAW scoreboard.
// Define DECODE_WB_BYPASS_EN to let a same-cycle writeback clear hazards and forward wb_data into operands.
module decode_issue_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS = 16,
  parameter int STALL_CNT_W = 16,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instruction,
  output logic [REG_AW-1:0]      rd_addr1,
  output logic [REG_AW-1:0]      rd_addr2,
  input  logic [DATA_W-1:0]      rd_data1,
  input  logic [DATA_W-1:0]      rd_data2,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             alu_ctrl,
  output logic [DATA_W-1:0]      src1,
  output logic [DATA_W-1:0]      src2,
  output logic [REG_AW-1:0]      wr_addr,
  output logic                   reg_w_en,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [REG_AW-1:0] dest, src;
  logic imm_valid, wen, hazard, accept;
  logic [DATA_W-1:0] imm_ext, op1, op2;
  logic [NREGS-1:0] wb_mask, sb_eff, sb_q, sb_d;
  logic out_valid_q, out_valid_d, reg_w_en_q, reg_w_en_d;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    dest = instruction[24 +: REG_AW];
    src = instruction[20 +: REG_AW];
    imm_valid = instruction[16];
    wen = instruction[31:28] == 4'b0001 || instruction[31:28] == 4'b0010;
    imm_ext = DATA_W'($signed(instruction[15:0]));
    wb_mask = '0;
    wb_mask[wb_addr] = wb_valid;
`ifdef DECODE_WB_BYPASS_EN
    sb_eff = sb_q & ~wb_mask;
    op1 = (wb_valid && wb_addr == dest) ? wb_data : rd_data1;
    op2 = imm_valid ? imm_ext : (wb_valid && wb_addr == src) ? wb_data : rd_data2;
`else
    sb_eff = sb_q;
    op1 = rd_data1;
    op2 = imm_valid ? imm_ext : rd_data2;
`endif
    // dest is checked too so a second writer waits for the first (WAW)
    hazard = in_valid && (sb_eff[dest] || (!imm_valid && sb_eff[src]));
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept = in_valid && in_ready;
    sb_d = sb_q & ~wb_mask;
    sb_d[dest] = sb_d[dest] | (accept && wen);
    out_valid_d = accept || (out_valid_q && !out_ready);
    alu_ctrl_d = accept ? instruction[19:17] : alu_ctrl_q;
    src1_d = accept ? op1 : src1_q;
    src2_d = accept ? op2 : src2_q;
    wr_addr_d = accept ? dest : wr_addr_q;
    reg_w_en_d = accept ? wen : reg_w_en_q;
    stall_cnt_d = (hazard && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      wr_addr_q <= '0;
      reg_w_en_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q <= alu_ctrl_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      wr_addr_q <= wr_addr_d;
      reg_w_en_q <= reg_w_en_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign rd_addr1 = dest;
  assign rd_addr2 = src;
  assign out_valid = out_valid_q;
  assign alu_ctrl = alu_ctrl_q;
  assign src1 = src1_q;
  assign src2 = src2_q;
  assign wr_addr = wr_addr_q;
  assign reg_w_en = reg_w_en_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed scenarios plus a randomized run against a pending-set reference model.
module tb_decode_issue_stage;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, wb_valid = 1'b0, reg_w_en;
  logic [31:0] instruction = '0, rd_data1, rd_data2, wb_data = '0, src1, src2;
  logic [3:0] rd_addr1, rd_addr2, wb_addr = '0, wr_addr;
  logic [2:0] alu_ctrl;
  logic [1:0] stall_cnt;
  logic [31:0] rf [16];
  int checks = 0, errors = 0;

  initial forever #5 clk = ~clk;
  assign rd_data1 = rf[instruction[27:24]];
  assign rd_data2 = rf[instruction[23:20]];

  decode_issue_stage #(.DATA_W(32), .NREGS(16), .STALL_CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2), .wr_addr(wr_addr),
    .reg_w_en(reg_w_en), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s,
                                     input logic [2:0] f, input logic iv, input logic [15:0] imm);
    return {op, d, s, f, iv, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    wb_valid = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    instruction = '0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = mk(4'd1, 4'd3, 4'd0, 3'd5, 1'b1, 16'h0042);
    tick;
    instruction = mk(4'd0, 4'd3, 4'd3, 3'd0, 1'b0, 16'h0);
    tick;
    checks++;
    if (out_valid !== 1'b1 || stall_cnt !== 2'd1) begin
      errors++;
      $display("FAIL reset_pre: out_valid=%0b stall=%0d, expected 1 and 1", out_valid, stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, alu_ctrl, src1, src2, wr_addr, reg_w_en, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_async: ov=%0b alu=%0d s1=%h s2=%h wr=%0d wen=%0b st=%0d, expected all 0",
               out_valid, alu_ctrl, src1, src2, wr_addr, reg_w_en, stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sb_clear: in_ready=%0b expected 1", in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_decode;
    logic [31:0] e1, e2;
    do_reset;
    rf[3] = 32'd7;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = mk(4'd1, 4'd3, 4'd4, 3'd5, 1'b1, 16'hFFFE);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || rd_addr1 !== 4'd3 || rd_addr2 !== 4'd4) begin
      errors++;
      $display("FAIL decode_comb: rdy=%0b a1=%0d a2=%0d, expected 1 3 4", in_ready, rd_addr1, rd_addr2);
    end
    tick;
    checks++;
    if ({out_valid, alu_ctrl, src1, src2, wr_addr, reg_w_en} !== {1'b1, 3'd5, 32'd7, 32'hFFFFFFFE, 4'd3, 1'b1}) begin
      errors++;
      $display("FAIL decode_imm: ov=%0b alu=%0d s1=%h s2=%h wr=%0d wen=%0b, expected 1 5 7 fffffffe 3 1",
               out_valid, alu_ctrl, src1, src2, wr_addr, reg_w_en);
    end
    e1 = rf[5];
    e2 = rf[7];
    instruction = mk(4'd2, 4'd5, 4'd7, 3'd6, 1'b0, 16'h7FFF);
    tick;
    checks++;
    if ({alu_ctrl, src1, src2, wr_addr, reg_w_en} !== {3'd6, e1, e2, 4'd5, 1'b1}) begin
      errors++;
      $display("FAIL decode_reg: alu=%0d s1=%h s2=%h wr=%0d wen=%0b, expected 6 %h %h 5 1",
               alu_ctrl, src1, src2, wr_addr, reg_w_en, e1, e2);
    end
    instruction = mk(4'd3, 4'd6, 4'd8, 3'd2, 1'b1, 16'h7FFF);
    tick;
    checks++;
    if ({alu_ctrl, src2, reg_w_en} !== {3'd2, 32'h00007FFF, 1'b0}) begin
      errors++;
      $display("FAIL decode_nowrite: alu=%0d s2=%h wen=%0b, expected 2 00007fff 0", alu_ctrl, src2, reg_w_en);
    end
    instruction = mk(4'd0, 4'd9, 4'd3, 3'd0, 1'b0, 16'h0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_src_hazard: in_ready=%0b expected 0", in_ready);
    end
    instruction = mk(4'd0, 4'd3, 4'd9, 3'd0, 1'b1, 16'h0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL waw_dest_hazard: in_ready=%0b expected 0", in_ready);
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_raw_stall;
    do_reset;
    rf[3] = 32'h1111;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = mk(4'd1, 4'd3, 4'd0, 3'd1, 1'b1, 16'h0);
    tick;
    instruction = mk(4'd4, 4'd5, 4'd3, 3'd2, 1'b0, 16'h0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall_ready: cycle %0d in_ready=%0b expected 0", k, in_ready);
      end
      tick;
      checks++;
      if (stall_cnt !== 2'(k)) begin
        errors++;
        $display("FAIL raw_stall_cnt: cycle %0d got %0d expected %0d", k, stall_cnt, k);
      end
    end
    wb_valid = 1'b1;
    wb_addr = 4'd3;
    wb_data = 32'd9;
`ifdef DECODE_WB_BYPASS_EN
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ready: in_ready=%0b expected 1", in_ready);
    end
    tick;
    rf[3] = 32'd9;
    wb_valid = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, src2, stall_cnt} !== {1'b1, 32'd9, 2'd2}) begin
      errors++;
      $display("FAIL bypass_issue: ov=%0b s2=%h st=%0d, expected 1 9 2", out_valid, src2, stall_cnt);
    end
`else
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wb_cycle_ready: in_ready=%0b expected 0", in_ready);
    end
    tick;
    rf[3] = 32'd9;
    wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_wb_ready: in_ready=%0b expected 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, src2, stall_cnt} !== {1'b1, 32'd9, 2'd3}) begin
      errors++;
      $display("FAIL post_wb_issue: ov=%0b s2=%h st=%0d, expected 1 9 3", out_valid, src2, stall_cnt);
    end
`endif
    tick;
  endtask

  task automatic test_imm_no_stall;
    do_reset;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = mk(4'd1, 4'd3, 4'd0, 3'd1, 1'b1, 16'h0);
    tick;
    instruction = mk(4'd4, 4'd5, 4'd3, 3'd2, 1'b1, 16'h0010);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL imm_no_stall_ready: in_ready=%0b expected 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, alu_ctrl, src2, wr_addr, stall_cnt} !== {1'b1, 3'd2, 32'h10, 4'd5, 2'd0}) begin
      errors++;
      $display("FAIL imm_no_stall_issue: ov=%0b alu=%0d s2=%h wr=%0d st=%0d, expected 1 2 10 5 0",
               out_valid, alu_ctrl, src2, wr_addr, stall_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] e1;
    do_reset;
    e1 = rf[1];
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction = mk(4'd1, 4'd1, 4'd2, 3'd3, 1'b1, 16'h1234);
    tick;
    instruction = mk(4'd0, 4'd6, 4'd7, 3'd4, 1'b1, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready: cycle %0d in_ready=%0b expected 0", k, in_ready);
      end
      tick;
      checks++;
      if ({out_valid, alu_ctrl, src1, src2, wr_addr, reg_w_en, stall_cnt} !==
          {1'b1, 3'd3, e1, 32'h1234, 4'd1, 1'b1, 2'd0}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d ov=%0b alu=%0d s1=%h s2=%h wr=%0d wen=%0b st=%0d", k,
                 out_valid, alu_ctrl, src1, src2, wr_addr, reg_w_en, stall_cnt);
      end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      instruction = mk(4'd0, 4'(6 + j), 4'd7, 3'(j), 1'b1, 16'(16'h100 + j));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready: op %0d in_ready=%0b expected 1", j, in_ready);
      end
      tick;
      checks++;
      if ({out_valid, alu_ctrl, src2, wr_addr} !== {1'b1, 3'(j), 32'(16'h100 + j), 4'(6 + j)}) begin
        errors++;
        $display("FAIL stream_issue: op %0d ov=%0b alu=%0d s2=%h wr=%0d", j, out_valid, alu_ctrl, src2, wr_addr);
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: out_valid=%0b expected 0", out_valid);
    end
  endtask

  task automatic test_saturation;
    do_reset;
    out_ready = 1'b1;
    in_valid = 1'b1;
    instruction = mk(4'd1, 4'd3, 4'd0, 3'd1, 1'b1, 16'h0);
    tick;
    in_valid = 1'b0;
    instruction = mk(4'd0, 4'd5, 4'd3, 3'd0, 1'b0, 16'h0);
    repeat (2) tick;
    checks++;
    if (stall_cnt !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_count: st=%0d rdy=%0b expected 0 1", stall_cnt, in_ready);
    end
    in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      checks++;
      if (stall_cnt !== 2'(k < 3 ? k : 3)) begin
        errors++;
        $display("FAIL saturate: cycle %0d got %0d expected %0d", k, stall_cnt, k < 3 ? k : 3);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random;
    bit pend [16];
    bit ev, ewen, hz, rdy, b1, b2, wen;
    logic [2:0] ea;
    logic [3:0] ew, d, s;
    logic [31:0] e1, e2;
    int est;
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) begin
        do_reset;
        foreach (pend[i]) pend[i] = 1'b0;
        ev = 1'b0;
        est = 0;
      end
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 3) != 0;
      instruction = mk(4'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 3'($urandom),
                       1'($urandom), 16'($urandom));
      wb_addr = 4'($urandom);
      wb_valid = pend[wb_addr] && $urandom_range(0, 2) == 0;
      wb_data = $urandom;
      @(negedge clk);
      d = instruction[27:24];
      s = instruction[23:20];
      b1 = pend[d] && !(BYP && wb_valid && wb_addr == d);
      b2 = !instruction[16] && pend[s] && !(BYP && wb_valid && wb_addr == s);
      hz = in_valid && (b1 || b2);
      rdy = (!ev || out_ready) && !hz;
      wen = instruction[31:28] == 4'd1 || instruction[31:28] == 4'd2;
      checks++;
      if ({in_ready, rd_addr1, rd_addr2} !== {rdy, d, s}) begin
        errors++;
        $display("FAIL rand_comb: n=%0d rdy=%0b a1=%0d a2=%0d expected %0b %0d %0d",
                 n, in_ready, rd_addr1, rd_addr2, rdy, d, s);
      end
      if (hz && est < 3) est++;
      if (in_valid && rdy) begin
        ev = 1'b1;
        ea = instruction[19:17];
        e1 = (BYP && wb_valid && wb_addr == d) ? wb_data : rf[d];
        e2 = instruction[16] ? {{16{instruction[15]}}, instruction[15:0]} :
             (BYP && wb_valid && wb_addr == s) ? wb_data : rf[s];
        ew = d;
        ewen = wen;
      end else if (out_ready) ev = 1'b0;
      if (wb_valid) pend[wb_addr] = 1'b0;
      if (in_valid && rdy && wen) pend[d] = 1'b1;
      tick;
      if (wb_valid) rf[wb_addr] = wb_data;
      checks++;
      if (out_valid !== ev || stall_cnt !== 2'(est)) begin
        errors++;
        $display("FAIL rand_state: n=%0d ov=%0b st=%0d expected %0b %0d", n, out_valid, stall_cnt, ev, est);
      end
      if (ev) begin
        checks++;
        if ({alu_ctrl, src1, src2, wr_addr, reg_w_en} !== {ea, e1, e2, ew, ewen}) begin
          errors++;
          $display("FAIL rand_op: n=%0d alu=%0d s1=%h s2=%h wr=%0d wen=%0b expected %0d %h %h %0d %0b",
                   n, alu_ctrl, src1, src2, wr_addr, reg_w_en, ea, e1, e2, ew, ewen);
        end
      end
    end
    in_valid = 1'b0;
    wb_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_decode;
    test_raw_stall;
    test_imm_no_stall;
    test_backpressure;
    test_saturation;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
